hamming_encoder_stream: RTL and testbench
=========================================

HAMMING_ENCODER_STREAM -- requirements
Module: hamming_encoder_stream

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2, setting the number of output buffer entries (power of two, >=2).
REQ-002 The block SHALL have parameter CNT_W, default 16, setting the width of the delivered-codeword counter.
REQ-003 The block SHALL use port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL use port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL use port in_data  input  4  data nibble to encode.
REQ-006 The block SHALL use port in_valid  input  1  in_data is valid.
REQ-007 The block SHALL use port in_ready  output  1  block can accept a nibble this cycle.
REQ-008 The block SHALL use port out_code  output  7  head codeword.
REQ-009 The block SHALL use port out_valid  output  1  out_code is valid.
REQ-010 The block SHALL use port out_ready  input  1  consumer accepts out_code.
REQ-011 The block SHALL use port inj_req  input  1  one-cycle request to corrupt the next accepted codeword.
REQ-012 The block SHALL use port inj_pos  input  3  bit position to flip, 1..7; 0 means no flip.
REQ-013 The block SHALL use port inj_pending  output  1  an injection is armed and not yet applied.
REQ-014 The block SHALL use port code_cnt  output  CNT_W  count of codewords delivered.

Function
REQ-015 Encoding SHALL be Hamming(7,4): code[2]=d0, code[4]=d1, code[5]=d2, code[6]=d3, code[0]=d0^d1^d3, code[1]=d0^d2^d3, code[3]=d1^d2^d3, where d=in_data.
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both high at a clock edge; the encoded word is then written to the FIFO tail.
REQ-017 in_ready SHALL equal not-full, from registered state only; a pop in the same cycle does not raise in_ready while full (no pass-through).
REQ-018 out_valid SHALL equal not-empty; out_code SHALL show the head entry, held stable while out_valid and not out_ready.
REQ-019 An output transfer SHALL occur when out_valid and out_ready are both high; the head is then removed.
REQ-020 Latency SHALL be exactly 1 cycle: a word accepted at edge N into an empty FIFO is presented with out_valid high after edge N.
REQ-021 Simultaneous push and pop when neither full nor empty SHALL leave occupancy unchanged and preserve order.
REQ-022 Read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked so full and empty are unambiguous.
REQ-023 Pushes while full and pops while empty SHALL NOT occur by construction; the FIFO state SHALL not change on such attempts.
REQ-024 inj_req with inj_pos!=0 SHALL latch inj_pos and set inj_pending; inj_req with inj_pos=0 SHALL clear any armed injection.
REQ-025 When an input transfer occurs with inj_pending high, bit (pos-1) of that codeword SHALL be inverted before storage, and inj_pending SHALL clear.
REQ-026 inj_req in the same cycle as an input transfer SHALL apply its inj_pos to that transfer directly; inj_pending stays low afterwards.
REQ-027 A new inj_req while inj_pending is high SHALL replace the latched position.
REQ-028 code_cnt SHALL increment by 1 on every output transfer and wrap from all-ones to 0.

Reset
REQ-029 While rst is high at an edge: FIFO emptied, pointers 0, out_valid=0, in_ready=1 after the edge, inj_pending=0, code_cnt=0, out_code=0.
REQ-030 Reset asserted mid-stream SHALL discard all buffered words and any armed injection; in-flight handshakes in that cycle SHALL have no effect.

Verification
REQ-031 Reset, then in_data=4'hB accepted, out_ready=1 -> next cycle out_valid=1, out_code=7'h55, then code_cnt=1.
REQ-032 Encode all 16 nibbles back-to-back (0 -> 7'h00, F -> 7'h7F); each output decodes with zero syndrome, order preserved, one word per cycle.
REQ-033 Hold out_ready=0, push 3 words -> in_ready low after 2nd accept, out_code stable; raise out_ready -> words drain in order, in_ready returns 1 cycle after first pop.
REQ-034 inj_req with inj_pos=3, then push 4'hB -> out_code=7'h51, inj_pending 1 until accept then 0; next push 4'hB -> 7'h55.
REQ-035 Assert rst with 2 words buffered and injection armed -> out_valid=0, inj_pending=0, code_cnt=0 next cycle.
REQ-036 Drive 2^CNT_W+1 output transfers (CNT_W=4 build) -> code_cnt wraps 15 -> 0 -> 1.

Source files
------------

// File: rtl/hamming_encoder_stream.sv
// Hamming(7,4) encoder feeding a small output FIFO, with one-shot single-bit error injection.
// One cycle accept-to-present latency; in_ready is registered not-full, so a full buffer stalls input even while popping.
module hamming_encoder_stream #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [6:0]       out_code,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             inj_req,
  input  logic [2:0]       inj_pos,
  output logic             inj_pending,
  output logic [CNT_W-1:0] code_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  logic [6:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [2:0]       pos_q;
  logic             pend_q;
  logic [CNT_W-1:0] cnt_q;

  logic             push;
  logic             pop;
  logic [6:0]       enc;
  logic [6:0]       flip_mask;
  logic [2:0]       eff_pos;

  assign in_ready    = (count != DEPTH_C);
  assign out_valid   = (count != '0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_code    = out_valid ? mem[rd_ptr] : 7'd0;
  assign inj_pending = pend_q;
  assign code_cnt    = cnt_q;

  assign enc = {in_data[3], in_data[2], in_data[1],
                in_data[1] ^ in_data[2] ^ in_data[3],
                in_data[0],
                in_data[0] ^ in_data[2] ^ in_data[3],
                in_data[0] ^ in_data[1] ^ in_data[3]};

  // A request arriving with the transfer wins over any previously armed position.
  always_comb begin
    eff_pos   = 3'd0;
    flip_mask = 7'd0;
    if (inj_req)
      eff_pos = inj_pos;
    else if (pend_q)
      eff_pos = pos_q;
    for (int i = 0; i < 7; i++)
      flip_mask[i] = (eff_pos == 3'(i + 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pos_q  <= 3'd0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= 7'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc ^ flip_mask;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cnt_q  <= cnt_q + 1'b1;
      end
      if (push && !pop)
        count <= count + 1'b1;
      else if (!push && pop)
        count <= count - 1'b1;

      if (push) begin
        pend_q <= 1'b0;
      end else if (inj_req) begin
        pend_q <= (inj_pos != 3'd0);
        pos_q  <= inj_pos;
      end
    end
  end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Directed bench for hamming_encoder_stream with a queue scoreboard of expected codewords.
module tb_hamming_encoder_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] out_code;
  logic       out_valid;
  logic       out_ready;
  logic       inj_req;
  logic [2:0] inj_pos;
  logic       inj_pending;
  logic [3:0] code_cnt;

  hamming_encoder_stream #(.FIFO_DEPTH(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_code(out_code), .out_valid(out_valid), .out_ready(out_ready),
    .inj_req(inj_req), .inj_pos(inj_pos), .inj_pending(inj_pending), .code_cnt(code_cnt)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  int         n_out = 0;
  int         cyc = 0;
  bit         chk_syn = 1'b0;
  logic [6:0] sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] ham(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  function automatic logic [2:0] syn(input logic [6:0] c);
    return {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard consumer: every output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_empty", 32'(sb.size()), 32'd1);
      end else begin
        check("out_code", 32'(out_code), 32'(sb.pop_front()));
        if (chk_syn) check("syndrome", 32'(syn(out_code)), 32'd0);
        n_out++;
      end
    end
  end

  // Holds in_valid until accepted; leaves it high so callers can chain words back-to-back.
  task automatic send(input logic [3:0] d, input logic [6:0] e);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        sb.push_back(e);
        break;
      end
    end
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!out_valid && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic arm(input logic [2:0] p);
    inj_req = 1'b1;
    inj_pos = p;
    @(posedge clk); #1;
    inj_req = 1'b0;
    inj_pos = 3'd0;
  endtask

  int c0;
  int n0;

  initial begin
    rst = 1'b1; in_data = 4'd0; in_valid = 1'b0; out_ready = 1'b0; inj_req = 1'b0; inj_pos = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_inj_pending", 32'(inj_pending), 32'd0);
    check("rst_code_cnt", 32'(code_cnt), 32'd0);
    check("rst_out_code", 32'(out_code), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single word, one-cycle latency
    out_ready = 1'b1;
    send(4'hB, 7'h55);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_code", 32'(out_code), 32'h55);
    @(posedge clk); #1;
    check("lat_code_cnt", 32'(code_cnt), 32'd1);
    drain();

    // All 16 nibbles back-to-back, one accept per cycle
    chk_syn = 1'b1;
    n0 = n_out;
    c0 = cyc;
    for (int i = 0; i < 16; i++)
      send(4'(i), (i == 0) ? 7'h00 : (i == 15) ? 7'h7F : ham(4'(i)));
    check("b2b_cycles", 32'(cyc - c0), 32'd16);
    drain();
    check("b2b_count", 32'(n_out - n0), 32'd16);
    chk_syn = 1'b0;

    // Backpressure: fill, hold, then release
    out_ready = 1'b0;
    send(4'hA, ham(4'hA));
    check("bp_ready_after1", 32'(in_ready), 32'd1);
    send(4'h3, ham(4'h3));
    check("bp_ready_after2", 32'(in_ready), 32'd0);
    in_data = 4'hC;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_code", 32'(out_code), 32'(ham(4'hA)));
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_at_pop", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("bp_ready_after_pop", 32'(in_ready), 32'd1);
    send(4'hC, ham(4'hC));
    drain();

    // Injection at position 3, then clean
    arm(3'd3);
    check("inj_pending_armed", 32'(inj_pending), 32'd1);
    send(4'hB, 7'h51);
    check("inj_pending_used", 32'(inj_pending), 32'd0);
    send(4'hB, 7'h55);
    drain();

    // Request coincident with the transfer applies directly
    inj_req = 1'b1; inj_pos = 3'd1;
    send(4'h0, 7'h01);
    inj_req = 1'b0; inj_pos = 3'd0;
    check("inj_same_cycle_pending", 32'(inj_pending), 32'd0);
    drain();

    // Re-arm replaces position; pos 0 disarms
    arm(3'd3);
    arm(3'd7);
    send(4'hB, 7'h15);
    drain();
    arm(3'd5);
    arm(3'd0);
    check("inj_disarm", 32'(inj_pending), 32'd0);
    send(4'hB, 7'h55);
    drain();

    // Mid-stream reset discards buffered words and armed injection
    out_ready = 1'b0;
    send(4'h1, ham(4'h1));
    send(4'h2, ham(4'h2));
    in_valid = 1'b0;
    arm(3'd2);
    check("pre_rst_pending", 32'(inj_pending), 32'd1);
    rst = 1'b1; in_valid = 1'b1; in_data = 4'h3; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sb.delete();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_pending", 32'(inj_pending), 32'd0);
    check("mid_rst_code_cnt", 32'(code_cnt), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Counter wrap on 4-bit build
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++)
      send(4'(i), ham(4'(i)));
    drain();
    check("cnt_15", 32'(code_cnt), 32'd15);
    send(4'h7, ham(4'h7));
    drain();
    check("cnt_wrap0", 32'(code_cnt), 32'd0);
    send(4'h8, ham(4'h8));
    drain();
    check("cnt_wrap1", 32'(code_cnt), 32'd1);

    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
